// File: rtl/frame_reader.sv
// Read-side client for a frame_buffer port: requests a frame, strobes every
// address once, and streams the returned pixels through a 2-entry FIFO.
module frame_reader #(
    parameter  int depth = 76800,
    localparam int AW    = $clog2(depth)
) (
    input  logic          prep_clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          ack_read,
    output logic          rq_read,
    output logic          reading,
    output logic          read_clk,
    output logic [AW-1:0] read_addr,
    input  logic [14:0]   input_px_data,
    output logic [14:0]   px_data,
    output logic          px_valid,
    input  logic          px_ready,
    output logic          px_sof,
    output logic          px_eof,
    output logic          frame_done,
    output logic          frame_error
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FETCH,
        CAP,
        RELEASE
    } state_t;

    localparam logic [AW-1:0] LastAddr = AW'(depth - 1);

    state_t        state_q, state_d;
    logic          rq_read_q, rq_read_d;
    logic          reading_q, reading_d;
    logic          read_clk_q, read_clk_d;
    logic [AW-1:0] read_addr_q, read_addr_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_error_q, frame_error_d;

    // FIFO entry layout: {eof, sof, pixel[14:0]}
    logic [16:0]   fifo_q [2];
    logic [16:0]   fifo_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    logic          push;
    logic          pop;
    logic [16:0]   head;

    always_comb begin
        state_d       = state_q;
        rq_read_d     = rq_read_q;
        reading_d     = reading_q;
        read_clk_d    = read_clk_q;
        read_addr_d   = read_addr_q;
        frame_done_d  = 1'b0;
        frame_error_d = frame_error_q;
        push          = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && !ack_read) begin
                    state_d       = REQ;
                    rq_read_d     = 1'b1;
                    frame_error_d = 1'b0;
                end
            end
            REQ: begin
                if (ack_read) begin
                    rq_read_d   = 1'b0;
                    reading_d   = 1'b1;
                    read_addr_d = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (!ack_read) begin
                    reading_d     = 1'b0;
                    read_clk_d    = 1'b0;
                    frame_error_d = 1'b1;
                    state_d       = IDLE;
                end else if (count_q <= 2'd1) begin
                    // At most one entry now, so the CAP push cannot overflow
                    read_clk_d = 1'b1;
                    state_d    = CAP;
                end
            end
            CAP: begin
                read_clk_d = 1'b0;
                if (!ack_read) begin
                    reading_d     = 1'b0;
                    frame_error_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    push = 1'b1;
                    if (read_addr_q == LastAddr) begin
                        reading_d    = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = RELEASE;
                    end else begin
                        read_addr_d = read_addr_q + 1'b1;
                        state_d     = FETCH;
                    end
                end
            end
            RELEASE: begin
                if (!ack_read) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = (count_q != 2'd0) && px_ready;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {(read_addr_q == LastAddr), (read_addr_q == '0), input_px_data};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge prep_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            rq_read_q     <= 1'b0;
            reading_q     <= 1'b0;
            read_clk_q    <= 1'b0;
            read_addr_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            fifo_q        <= '{default: '0};
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            rq_read_q     <= rq_read_d;
            reading_q     <= reading_d;
            read_clk_q    <= read_clk_d;
            read_addr_q   <= read_addr_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    assign head        = fifo_q[rd_ptr_q];
    assign rq_read     = rq_read_q;
    assign reading     = reading_q;
    assign read_clk    = read_clk_q;
    assign read_addr   = read_addr_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign px_valid    = (count_q != 2'd0);
    assign px_data     = head[14:0];
    assign px_sof      = px_valid & head[15];
    assign px_eof      = px_valid & head[16];

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader with depth=8 and a buffer model returning addr+0x100.
module tb_frame_reader;

    localparam int Depth = 8;
    localparam int AW    = $clog2(Depth);

    logic          prep_clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          ack_read;
    logic          rq_read;
    logic          reading;
    logic          read_clk;
    logic [AW-1:0] read_addr;
    logic [14:0]   input_px_data = '0;
    logic [14:0]   px_data;
    logic          px_valid;
    logic          px_ready;
    logic          px_sof;
    logic          px_eof;
    logic          frame_done;
    logic          frame_error;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cnt = 0;
    logic rclk_prev = 1'b0;
    logic [16:0] mon_q[$];
    int          rise_cyc[$];

    frame_reader #(.depth(Depth)) dut (
        .prep_clk      (prep_clk),
        .reset         (reset),
        .enable        (enable),
        .ack_read      (ack_read),
        .rq_read       (rq_read),
        .reading       (reading),
        .read_clk      (read_clk),
        .read_addr     (read_addr),
        .input_px_data (input_px_data),
        .px_data       (px_data),
        .px_valid      (px_valid),
        .px_ready      (px_ready),
        .px_sof        (px_sof),
        .px_eof        (px_eof),
        .frame_done    (frame_done),
        .frame_error   (frame_error)
    );

    always #5 prep_clk = ~prep_clk;

    always @(posedge prep_clk) cyc <= cyc + 1;

    // Buffer model: latches the addressed word on the strobe's rising edge
    always @(posedge read_clk) input_px_data = 15'h100 + 15'(read_addr);

    always @(negedge prep_clk) begin
        if (px_valid && px_ready) mon_q.push_back({px_eof, px_sof, px_data});
        if (read_clk && !rclk_prev) rise_cyc.push_back(cyc);
        rclk_prev = read_clk;
        if (frame_done) done_cnt++;
    end

    function automatic logic [16:0] exp_px(int i);
        logic [14:0] d;
        d = 15'h100 + 15'(i % Depth);
        return {((i % Depth) == Depth - 1), ((i % Depth) == 0), d};
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge prep_clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        mon_q.delete();
        rise_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic wait_rq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rq_read) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_done(output bit ok, output logic done_at_fall);
        ok = 1'b0;
        done_at_fall = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick(1);
            if (!reading) begin
                ok = 1'b1;
                done_at_fall = frame_done;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [27:0] outs;
        reset = 1'b0; enable = 1'b0; ack_read = 1'b0; px_ready = 1'b1;
        #2;
        outs = {rq_read, reading, read_clk, read_addr, px_valid, px_sof, px_eof,
                frame_done, frame_error, px_data};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        tick(2);
        reset = 1'b1;
        tick(2);
        checks++;
        if (rq_read !== 1'b0) begin
            errors++; $display("FAIL idle_no_request: got %b expected 0", rq_read);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic dfall;
        clear_mon();
        enable = 1'b1;
        wait_rq(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_rq_timeout: got 0 expected 1"); end
        tick(3);
        checks++;
        if (rq_read !== 1'b1) begin
            errors++; $display("FAIL basic_rq_hold: got %b expected 1", rq_read);
        end
        ack_read = 1'b1;
        tick(1);
        checks++;
        if ({reading, rq_read, read_clk} !== 3'b100) begin
            errors++; $display("FAIL basic_grant: got %b expected 100", {reading, rq_read, read_clk});
        end
        tick(1);
        checks++;
        if (read_clk !== 1'b1) begin
            errors++; $display("FAIL basic_first_strobe: got %b expected 1", read_clk);
        end
        wait_done(ok, dfall);
        checks++;
        if (!ok || dfall !== 1'b1) begin
            errors++; $display("FAIL basic_done_with_fall: got ok=%b done=%b expected 1 1", ok, dfall);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (rq_read !== 1'b0) begin
                errors++; $display("FAIL basic_no_rerequest: got %b expected 0", rq_read);
            end
        end
        enable = 1'b0;
        ack_read = 1'b0;
        tick(4);
        checks++;
        if (mon_q.size() != Depth) begin
            errors++; $display("FAIL basic_px_count: got %0d expected %0d", mon_q.size(), Depth);
        end else begin
            for (int i = 0; i < Depth; i++) begin
                checks++;
                if (mon_q[i] !== exp_px(i)) begin
                    errors++; $display("FAIL basic_px[%0d]: got %h expected %h", i, mon_q[i], exp_px(i));
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt);
        end
        checks++;
        if (rise_cyc.size() != Depth) begin
            errors++; $display("FAIL basic_strobe_count: got %0d expected %0d", rise_cyc.size(), Depth);
        end else begin
            for (int i = 1; i < Depth; i++) begin
                checks++;
                if (rise_cyc[i] - rise_cyc[i-1] != 2) begin
                    errors++; $display("FAIL basic_strobe_gap[%0d]: got %0d expected 2", i, rise_cyc[i] - rise_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic dfall;
        clear_mon();
        enable = 1'b1;
        wait_rq(ok);
        enable = 1'b0;
        ack_read = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (mon_q.size() == 2) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_start_timeout: got 0 expected 1"); end
        px_ready = 1'b0;
        tick(20);
        checks++;
        if (read_addr !== 3'd4) begin
            errors++; $display("FAIL bp_addr_frozen: got %0d expected 4", read_addr);
        end
        checks++;
        if ({px_valid, px_data} !== {1'b1, 15'h102}) begin
            errors++; $display("FAIL bp_head: got %b %h expected 1 102", px_valid, px_data);
        end
        checks++;
        if (rise_cyc.size() != 4 || read_clk !== 1'b0) begin
            errors++; $display("FAIL bp_strobes_stopped: got %0d/%b expected 4/0", rise_cyc.size(), read_clk);
        end
        px_ready = 1'b1;
        wait_done(ok, dfall);
        ack_read = 1'b0;
        tick(4);
        checks++;
        if (mon_q.size() != Depth) begin
            errors++; $display("FAIL bp_px_count: got %0d expected %0d", mon_q.size(), Depth);
        end else begin
            for (int i = 0; i < Depth; i++) begin
                checks++;
                if (mon_q[i] !== exp_px(i)) begin
                    errors++; $display("FAIL bp_px[%0d]: got %h expected %h", i, mon_q[i], exp_px(i));
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_abort();
        bit ok;
        clear_mon();
        enable = 1'b1;
        wait_rq(ok);
        enable = 1'b0;
        ack_read = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (reading && read_addr == 3'd4) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_reach_timeout: got 0 expected 1"); end
        ack_read = 1'b0;
        tick(1);
        checks++;
        if ({reading, frame_error, read_clk} !== 3'b010) begin
            errors++; $display("FAIL abort_flags: got %b expected 010", {reading, frame_error, read_clk});
        end
        tick(4);
        checks++;
        if (mon_q.size() != 4) begin
            errors++; $display("FAIL abort_px_count: got %0d expected 4", mon_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mon_q[i] !== exp_px(i)) begin
                    errors++; $display("FAIL abort_px[%0d]: got %h expected %h", i, mon_q[i], exp_px(i));
                end
            end
        end
        checks++;
        if (done_cnt != 0 || frame_error !== 1'b1) begin
            errors++; $display("FAIL abort_sticky: got done=%0d err=%b expected 0 1", done_cnt, frame_error);
        end
        enable = 1'b1;
        tick(1);
        checks++;
        if ({rq_read, frame_error} !== 2'b10) begin
            errors++; $display("FAIL abort_err_cleared: got %b expected 10", {rq_read, frame_error});
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic dfall;
        logic [27:0] outs;
        enable = 1'b0;
        ack_read = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (reading && read_addr == 3'd5) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL areset_reach_timeout: got 0 expected 1"); end
        #2;
        reset = 1'b0;
        #1;
        outs = {rq_read, reading, read_clk, read_addr, px_valid, px_sof, px_eof,
                frame_done, frame_error, px_data};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL areset_outputs: got %h expected 0", outs);
        end
        tick(2);
        ack_read = 1'b0;
        reset = 1'b1;
        enable = 1'b1;
        clear_mon();
        wait_rq(ok);
        enable = 1'b0;
        ack_read = 1'b1;
        wait_done(ok, dfall);
        checks++;
        if (!ok) begin errors++; $display("FAIL areset_frame_timeout: got 0 expected 1"); end
        ack_read = 1'b0;
        tick(4);
        checks++;
        if (mon_q.size() != Depth) begin
            errors++; $display("FAIL areset_px_count: got %0d expected %0d", mon_q.size(), Depth);
        end else begin
            for (int i = 0; i < Depth; i++) begin
                checks++;
                if (mon_q[i] !== exp_px(i)) begin
                    errors++; $display("FAIL areset_px[%0d]: got %h expected %h", i, mon_q[i], exp_px(i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic dfall;
        clear_mon();
        enable = 1'b1;
        wait_rq(ok);
        ack_read = 1'b1;
        wait_done(ok, dfall);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_frame1_timeout: got 0 expected 1"); end
        ack_read = 1'b0;
        tick(1);
        checks++;
        if (rq_read !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: got %b expected 0", rq_read);
        end
        tick(1);
        checks++;
        if (rq_read !== 1'b1) begin
            errors++; $display("FAIL b2b_rerequest: got %b expected 1", rq_read);
        end
        ack_read = 1'b1;
        wait_done(ok, dfall);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_frame2_timeout: got 0 expected 1"); end
        enable = 1'b0;
        ack_read = 1'b0;
        tick(4);
        checks++;
        if (mon_q.size() != 2 * Depth) begin
            errors++; $display("FAIL b2b_px_count: got %0d expected %0d", mon_q.size(), 2 * Depth);
        end else begin
            for (int i = 0; i < 2 * Depth; i++) begin
                checks++;
                if (mon_q[i] !== exp_px(i)) begin
                    errors++; $display("FAIL b2b_px[%0d]: got %h expected %h", i, mon_q[i], exp_px(i));
                end
            end
        end
        checks++;
        if (done_cnt != 2 || rise_cyc.size() != 2 * Depth) begin
            errors++; $display("FAIL b2b_done_strobes: got %0d/%0d expected 2/%0d", done_cnt, rise_cyc.size(), 2 * Depth);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
